// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI responder
package spi_pkg;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  localparam logic       LANE_SINGLE = 1'b0;
  localparam logic       LANE_QUAD   = 1'b1;
  localparam logic [3:0] SE_SINGLE   = 4'b0010;
  localparam int         MISO_BIT    = 1;

  // Counter value of the last bit/nibble of a byte for the given lane mode.
  function automatic logic [2:0] last_cnt(input logic lane);
    return (lane == LANE_QUAD) ? 3'd1 : 3'd7;
  endfunction

  // Quad receive-only transfers never drive the bus, so they never pull tx bytes.
  function automatic logic tx_lane_on(input logic lane, input logic drive);
    return (lane == LANE_SINGLE) || drive;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - STAGES-deep single-bit synchroniser with selectable reset value
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic ck,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - oversampled SPI mode-0 responder, single and quad lanes
// Optional feature macro SPI_RESPONDER_STATS_EN adds the rx_count byte counter output.
module spi_responder
  import spi_pkg::*;
#(
  parameter logic [7:0] FILL        = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        ck,
  input  logic        nrst,
  input  logic        s_ck,
  input  logic        s_ncs,
  input  logic [3:0]  s_si,
  output logic [3:0]  s_so,
  output logic [3:0]  s_se,
  input  logic        quad,
  input  logic        dir,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        tx_underrun,
  output logic        active
`ifdef SPI_RESPONDER_STATS_EN
  ,
  output logic [15:0] rx_count
`endif
);

  logic       ck_s;
  logic       ncs_s;
  logic [3:0] si_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ck (
    .ck   (ck),
    .nrst (nrst),
    .d    (s_ck),
    .q    (ck_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .ck   (ck),
    .nrst (nrst),
    .d    (s_ncs),
    .q    (ncs_s)
  );

  for (genvar i = 0; i < 4; i++) begin : g_si
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_si (
      .ck   (ck),
      .nrst (nrst),
      .d    (s_si[i]),
      .q    (si_s[i])
    );
  end

  logic       ck_p_q, ck_p_d;
  logic       ncs_p_q, ncs_p_d;
  state_e     state_q, state_d;
  logic       quad_q, quad_d;
  logic       dir_q, dir_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;

  logic       sck_rise, sck_fall, ncs_fall, ncs_rise;
  logic       load;
  logic [7:0] rx_next;

  assign sck_rise = ck_s & ~ck_p_q;
  assign sck_fall = ~ck_s & ck_p_q;
  assign ncs_fall = ~ncs_s & ncs_p_q;
  assign ncs_rise = ncs_s & ~ncs_p_q;

  always_comb begin
    ck_p_d     = ck_s;
    ncs_p_d    = ncs_s;
    state_d    = state_q;
    quad_d     = quad_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    load       = 1'b0;
    rx_next    = (quad_q == LANE_QUAD) ? {rx_sh_q[3:0], si_s} : {rx_sh_q[6:0], si_s[0]};

    case (state_q)
      IDLE: begin
        // SCK activity before chip select is ignored, including a coincident rise.
        if (ncs_fall) begin
          state_d = ACTIVE;
          quad_d  = quad;
          dir_d   = dir;
          cnt_d   = 3'd0;
          load    = tx_lane_on(quad, dir);
        end
      end
      ACTIVE: begin
        if (ncs_rise) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (sck_rise) begin
          rx_sh_d = rx_next;
          if (cnt_q == last_cnt(quad_q)) begin
            cnt_d      = 3'd0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (sck_fall) begin
          if (cnt_q == 3'd0) begin
            load = tx_lane_on(quad_q, dir_q);
          end else if (quad_q == LANE_QUAD) begin
            tx_sh_d = {tx_sh_q[3:0], 4'h0};
          end else begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      tx_sh_d = tx_valid ? tx_data : FILL;
    end
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      ck_p_q     <= 1'b0;
      ncs_p_q    <= 1'b1;
      state_q    <= IDLE;
      quad_q     <= LANE_SINGLE;
      dir_q      <= 1'b0;
      cnt_q      <= 3'd0;
      rx_sh_q    <= 8'h00;
      tx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      ck_p_q     <= ck_p_d;
      ncs_p_q    <= ncs_p_d;
      state_q    <= state_d;
      quad_q     <= quad_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Pad drive comes straight from registered state, so the first bit is out the cycle after LOAD.
  always_comb begin
    active = (state_q == ACTIVE);
    s_se   = 4'h0;
    s_so   = 4'h0;
    if (active) begin
      if (quad_q == LANE_SINGLE) begin
        s_se           = SE_SINGLE;
        s_so[MISO_BIT] = tx_sh_q[7];
      end else if (dir_q) begin
        s_se = 4'hF;
        s_so = tx_sh_q[7:4];
      end
    end
  end

  assign tx_ready    = load & tx_valid;
  assign tx_underrun = load & ~tx_valid;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;

`ifdef SPI_RESPONDER_STATS_EN
  logic [15:0] rx_count_q, rx_count_d;

  always_comb begin
    rx_count_d = rx_count_q;
    if ((state_q == IDLE) && ncs_fall) begin
      rx_count_d = 16'h0000;
    end else if (rx_valid_d && (rx_count_q != 16'hFFFF)) begin
      rx_count_d = rx_count_q + 16'd1;
    end
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      rx_count_q <= 16'h0000;
    end else begin
      rx_count_q <= rx_count_d;
    end
  end

  assign rx_count = rx_count_q;
`endif

endmodule
